pend_stamp: RTL and testbench

- Consumer side of the monotonic timer: samples the free-running timer value (`direct_out` of `timer`) when an interrupt vector's pend line rises.
- Holds one time stamp per vector and exposes stamps plus a status word through the CSR read/modify path.
- Sits next to the interrupt controller. The dispatcher and software read arrival times to measure response time and jitter.

---
 rtl/pend_stamp_pkg.sv | 56 +++++
 rtl/pend_stamp_entry.sv | 54 +++++
 rtl/pend_stamp.sv | 64 ++++++
 tb/tb_pend_stamp.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pend_stamp_pkg.sv
// Shared types, CSR map and status-word layout for the pend_stamp block.
package pend_stamp_pkg;

   localparam int unsigned VecSize          = 8;
   localparam int unsigned TimerWidth       = 24;
   localparam int unsigned CsrAddrWidth     = 12;
   localparam int unsigned WordWidth        = 32;
   localparam int unsigned RegWidth         = 5;
   localparam int unsigned StatusOverrunLsb = 16;

   typedef logic [CsrAddrWidth-1:0] CsrAddrT;
   typedef logic [WordWidth-1:0]    word;
   typedef logic [RegWidth-1:0]     r;
   typedef logic [TimerWidth-1:0]   TimerT;

   typedef enum logic [2:0] {
      CSR_NONE = 3'b000,
      CSR_RW   = 3'b001,
      CSR_RS   = 3'b010,
      CSR_RC   = 3'b011,
      CSR_RWI  = 3'b101,
      CSR_RSI  = 3'b110,
      CSR_RCI  = 3'b111
   } csr_op_t;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      CAPTURED = 2'd1,
      OVERRUN  = 2'd2
   } StampStateT;

   localparam CsrAddrT StampCsrBase = 12'hB40;
   localparam CsrAddrT StatusCsr    = 12'hB3F;

   // Status word layout: valid in the low byte lane, overrun from bit 16.
   typedef struct packed {
      logic [WordWidth-StatusOverrunLsb-VecSize-1:0] rsvd_hi;
      logic [VecSize-1:0]                            overrun;
      logic [StatusOverrunLsb-VecSize-1:0]           rsvd_lo;
      logic [VecSize-1:0]                            valid;
   } status_t;

   // Bits of the status word a CSR write asks to clear; software can never set.
   function automatic word status_clear_mask(csr_op_t op, word rs1_data, r zimm);
      word operand;
      word mask;
      operand = (op inside {CSR_RWI, CSR_RSI, CSR_RCI}) ? WordWidth'(zimm) : rs1_data;
      case (op)
         CSR_RW, CSR_RWI: mask = ~operand;
         CSR_RC, CSR_RCI: mask = operand;
         default:         mask = '0;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/pend_stamp_entry.sv
// One vector's arrival stamp: pend edge detector, EMPTY/CAPTURED/OVERRUN state, stamp register.
// PEND_STAMP_OVERRUN_EN: keep the first stamp and flag overrun on a repeat rise; otherwise latest rise wins.
module pend_stamp_entry
   import pend_stamp_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  TimerT mono_timer,
   input  logic  pend,
   input  logic  clear_valid,
   input  logic  clear_overrun,
   output TimerT stamp,
   output logic  valid,
   output logic  overrun
);

   StampStateT state;
   logic       pend_q;
   logic       rise;

   assign rise = pend & ~pend_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         stamp  <= '0;
         // A line held high across reset is not a new arrival.
         pend_q <= pend;
      end else begin
         pend_q <= pend;
         if (rise) begin
`ifdef PEND_STAMP_OVERRUN_EN
            if (state == EMPTY || clear_valid) begin
               stamp <= mono_timer;
               state <= CAPTURED;
            end else begin
               state <= OVERRUN;
            end
`else
            stamp <= mono_timer;
            state <= CAPTURED;
`endif
         end else if (clear_valid) begin
            state <= EMPTY;
         end else if (clear_overrun && state == OVERRUN) begin
            state <= CAPTURED;
         end
      end
   end

   assign valid   = (state != EMPTY);
   assign overrun = (state == OVERRUN);

endmodule

// File: rtl/pend_stamp.sv
// Per-vector arrival time stamps with a CSR status/clear interface.
// Build option PEND_STAMP_OVERRUN_EN enables overrun tracking in each entry.
module pend_stamp
   import pend_stamp_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  TimerT              mono_timer,
   input  logic [VecSize-1:0] pend,
   input  logic               csr_enable,
   input  CsrAddrT            csr_addr,
   input  csr_op_t            csr_op,
   input  r                   rs1_zimm,
   input  word                rs1_data,
   output word                csr_out
);

   TimerT              stamp [VecSize];
   logic [VecSize-1:0] valid;
   logic [VecSize-1:0] overrun;
   logic               status_wr;
   status_t            clr;
   status_t            status_word;
   logic               unused_rsvd;

   assign status_wr   = csr_enable && (csr_addr == StatusCsr);
   assign clr         = status_wr ? status_t'(status_clear_mask(csr_op, rs1_data, rs1_zimm))
                                  : status_t'('0);
   assign unused_rsvd = ^{clr.rsvd_hi, clr.rsvd_lo};

   for (genvar k = 0; k < VecSize; k++) begin : g_entry
      pend_stamp_entry u_entry (
         .clk           (clk),
         .reset         (reset),
         .mono_timer    (mono_timer),
         .pend          (pend[k]),
         .clear_valid   (clr.valid[k]),
         .clear_overrun (clr.overrun[k]),
         .stamp         (stamp[k]),
         .valid         (valid[k]),
         .overrun       (overrun[k])
      );
   end

   always_comb begin
      status_word         = '0;
      status_word.valid   = valid;
      status_word.overrun = overrun;
   end

   // Zero-cycle read mux; undecoded addresses read zero.
   always_comb begin
      csr_out = '0;
      if (csr_addr == StatusCsr) begin
         csr_out = status_word;
      end
      for (int k = 0; k < VecSize; k++) begin
         if (csr_addr == StampCsrBase + CsrAddrWidth'(k)) begin
            csr_out = WordWidth'(stamp[k]);
         end
      end
   end

endmodule

// File: tb/tb_pend_stamp.sv
// Self-checking bench for pend_stamp: directed scenarios plus randomized traffic vs. a reference model.
module tb_pend_stamp;
   import pend_stamp_pkg::*;

`ifdef PEND_STAMP_OVERRUN_EN
   localparam bit OvEn = 1'b1;
`else
   localparam bit OvEn = 1'b0;
`endif

   logic               clk;
   logic               reset;
   TimerT              mono_timer;
   logic [VecSize-1:0] pend;
   logic               csr_enable;
   CsrAddrT            csr_addr;
   csr_op_t            csr_op;
   r                   rs1_zimm;
   word                rs1_data;
   word                csr_out;

   int n_checks;
   int n_fail;

   // Reference model: arrival record per vector.
   int unsigned        m_stamp [VecSize];
   bit                 m_valid [VecSize];
   bit                 m_over  [VecSize];
   bit [VecSize-1:0]   m_prev;

   pend_stamp dut (
      .clk        (clk),
      .reset      (reset),
      .mono_timer (mono_timer),
      .pend       (pend),
      .csr_enable (csr_enable),
      .csr_addr   (csr_addr),
      .csr_op     (csr_op),
      .rs1_zimm   (rs1_zimm),
      .rs1_data   (rs1_data),
      .csr_out    (csr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_update();
      word operand;
      word clear;
      bit  rise;
      if (reset) begin
         for (int k = 0; k < VecSize; k++) begin
            m_stamp[k] = 0;
            m_valid[k] = 0;
            m_over[k]  = 0;
         end
         m_prev = pend;
         return;
      end
      clear = '0;
      if (csr_enable && csr_addr == StatusCsr) begin
         if (csr_op == CSR_RWI || csr_op == CSR_RSI || csr_op == CSR_RCI)
            operand = {27'd0, rs1_zimm};
         else
            operand = rs1_data;
         if (csr_op == CSR_RW || csr_op == CSR_RWI) clear = ~operand;
         else if (csr_op == CSR_RC || csr_op == CSR_RCI) clear = operand;
      end
      for (int k = 0; k < VecSize; k++) begin
         rise = pend[k] && !m_prev[k];
         if (rise) begin
            if (OvEn && m_valid[k] && !clear[k]) begin
               m_over[k] = 1;
            end else begin
               m_stamp[k] = int'(mono_timer);
               m_valid[k] = 1;
               m_over[k]  = 0;
            end
         end else if (clear[k]) begin
            m_valid[k] = 0;
            m_over[k]  = 0;
         end else if (clear[16+k]) begin
            m_over[k] = 0;
         end
      end
      m_prev = pend;
   endtask

   function automatic word exp_read(CsrAddrT a);
      word w;
      w = '0;
      if (a == StatusCsr) begin
         for (int k = 0; k < VecSize; k++) begin
            w[k]    = m_valid[k];
            w[16+k] = m_over[k];
         end
      end
      for (int k = 0; k < VecSize; k++)
         if (a == StampCsrBase + CsrAddrT'(k)) w = word'(m_stamp[k]);
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic read_csr(input CsrAddrT a, output word d);
      csr_enable = 1'b0;
      csr_addr   = a;
      #1;
      d = csr_out;
   endtask

   task automatic csr_write(input CsrAddrT a, input csr_op_t op, input word data, input r zimm);
      csr_enable = 1'b1;
      csr_addr   = a;
      csr_op     = op;
      rs1_data   = data;
      rs1_zimm   = zimm;
   endtask

   task automatic test_reset();
      word d;
      reset = 1'b1; mono_timer = 24'd7; pend = 8'h02;
      tick(); tick();
      reset = 1'b0;
      tick();
      read_csr(StampCsrBase + 12'd1, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_stamp1: got 0x%08h expected 0x%08h", d, 32'd0); end
      read_csr(StatusCsr, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_status: got 0x%08h expected 0x%08h", d, 32'd0); end
      pend = 8'h00;
      tick();
      read_csr(StatusCsr, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL reset_held_pend: got 0x%08h expected 0x%08h", d, 32'd0); end
   endtask

   task automatic test_capture();
      word d;
      mono_timer = 24'd11; pend = 8'h02;
      tick();
      read_csr(StampCsrBase + 12'd1, d);
      n_checks++;
      if (d !== 32'd11) begin n_fail++; $display("FAIL capture_stamp1: got 0x%08h expected 0x%08h", d, 32'd11); end
      read_csr(StatusCsr, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL capture_status: got 0x%08h expected 0x%08h", d, 32'h2); end
      pend = 8'h00; #1; pend = 8'h02;
      mono_timer = 24'd12;
      tick();
      read_csr(StampCsrBase + 12'd1, d);
      n_checks++;
      if (d !== 32'd11) begin n_fail++; $display("FAIL glitch_stamp1: got 0x%08h expected 0x%08h", d, 32'd11); end
      read_csr(StatusCsr, d);
      n_checks++;
      if (d !== 32'h2) begin n_fail++; $display("FAIL glitch_status: got 0x%08h expected 0x%08h", d, 32'h2); end
   endtask

   task automatic test_multi_rise();
      word d;
      csr_write(StatusCsr, CSR_RW, 32'd0, 5'd0);
      pend = 8'h00;
      tick();
      csr_enable = 1'b0;
      tick();
      mono_timer = 24'd20; pend = 8'h06;
      tick();
      read_csr(StampCsrBase + 12'd1, d);
      n_checks++;
      if (d !== 32'd20) begin n_fail++; $display("FAIL multi_stamp1: got 0x%08h expected 0x%08h", d, 32'd20); end
      read_csr(StampCsrBase + 12'd2, d);
      n_checks++;
      if (d !== 32'd20) begin n_fail++; $display("FAIL multi_stamp2: got 0x%08h expected 0x%08h", d, 32'd20); end
      read_csr(StatusCsr, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL multi_status: got 0x%08h expected 0x%08h", d, 32'h6); end
   endtask

   task automatic test_overrun();
      word d;
      word exp_s;
      pend = 8'h04;
      tick();
      mono_timer = 24'd30; pend = 8'h06;
      tick();
      exp_s = OvEn ? 32'd20 : 32'd30;
      read_csr(StampCsrBase + 12'd1, d);
      n_checks++;
      if (d !== exp_s) begin n_fail++; $display("FAIL overrun_stamp1: got 0x%08h expected 0x%08h", d, exp_s); end
      exp_s = OvEn ? 32'h0002_0006 : 32'h6;
      read_csr(StatusCsr, d);
      n_checks++;
      if (d !== exp_s) begin n_fail++; $display("FAIL overrun_status: got 0x%08h expected 0x%08h", d, exp_s); end
   endtask

   task automatic test_clear_race();
      word d;
      pend = 8'h04;
      tick();
      csr_write(StatusCsr, CSR_RCI, 32'd0, 5'd2);
      mono_timer = 24'd40; pend = 8'h06;
      tick();
      read_csr(StampCsrBase + 12'd1, d);
      n_checks++;
      if (d !== 32'd40) begin n_fail++; $display("FAIL race_stamp1: got 0x%08h expected 0x%08h", d, 32'd40); end
      read_csr(StatusCsr, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL race_status: got 0x%08h expected 0x%08h", d, 32'h6); end
   endtask

   task automatic test_readonly_and_clear();
      word d;
      csr_write(StampCsrBase + 12'd2, CSR_RW, 32'h0000_FFFF, 5'd0);
      mono_timer = 24'd50;
      tick();
      read_csr(StampCsrBase + 12'd2, d);
      n_checks++;
      if (d !== 32'd20) begin n_fail++; $display("FAIL ro_stamp2: got 0x%08h expected 0x%08h", d, 32'd20); end
      csr_write(StatusCsr, CSR_RS, 32'hFFFF_FFFF, 5'd0);
      tick();
      read_csr(StatusCsr, d);
      n_checks++;
      if (d !== 32'h6) begin n_fail++; $display("FAIL rs_noeffect: got 0x%08h expected 0x%08h", d, 32'h6); end
      csr_write(StatusCsr, CSR_RW, 32'd0, 5'd0);
      tick();
      read_csr(StatusCsr, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL rw_clear_status: got 0x%08h expected 0x%08h", d, 32'd0); end
      read_csr(StampCsrBase + 12'd1, d);
      n_checks++;
      if (d !== 32'd40) begin n_fail++; $display("FAIL rw_keep_stamp1: got 0x%08h expected 0x%08h", d, 32'd40); end
      read_csr(StampCsrBase + 12'd8, d);
      n_checks++;
      if (d !== 32'd0) begin n_fail++; $display("FAIL decode_past_end: got 0x%08h expected 0x%08h", d, 32'd0); end
   endtask

   task automatic test_random();
      word     d;
      word     e;
      CsrAddrT a;
      csr_op_t ops [6] = '{CSR_RW, CSR_RS, CSR_RC, CSR_RWI, CSR_RSI, CSR_RCI};
      for (int i = 0; i < 400; i++) begin
         reset      = ($urandom_range(0, 39) == 0);
         pend       = 8'($urandom);
         mono_timer = TimerT'($urandom);
         csr_enable = $urandom_range(0, 1) == 1;
         csr_addr   = ($urandom_range(0, 9) < 7) ? StatusCsr : 12'hB3C + 12'($urandom_range(0, 15));
         csr_op     = ops[$urandom_range(0, 5)];
         rs1_data   = $urandom;
         rs1_zimm   = 5'($urandom);
         tick();
         reset = 1'b0;
         read_csr(StatusCsr, d);
         e = exp_read(StatusCsr);
         n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL rand_status cyc %0d: got 0x%08h expected 0x%08h", i, d, e); end
         a = StampCsrBase + 12'($urandom_range(0, VecSize - 1));
         read_csr(a, d);
         e = exp_read(a);
         n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL rand_stamp cyc %0d addr %h: got 0x%08h expected 0x%08h", i, a, d, e); end
         a = 12'hB3C + 12'($urandom_range(0, 15));
         read_csr(a, d);
         e = exp_read(a);
         n_checks++;
         if (d !== e) begin n_fail++; $display("FAIL rand_addr cyc %0d addr %h: got 0x%08h expected 0x%08h", i, a, d, e); end
      end
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      m_prev     = '0;
      reset      = 1'b1;
      mono_timer = '0;
      pend       = '0;
      csr_enable = 1'b0;
      csr_addr   = '0;
      csr_op     = CSR_NONE;
      rs1_zimm   = '0;
      rs1_data   = '0;
      test_reset();
      test_capture();
      test_multi_rise();
      test_overrun();
      test_clear_race();
      test_readonly_and_clear();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
